tlb_op_ctrl: RTL and testbench
==============================

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 Parameter: SRCH_TIMEOUT, default 4, max cycles waiting for s_ok before an aborted search.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 req_valid / req_ready  in / out  1 / 1  op request handshake from execute stage.
REQ-005 req_op  in  tlb_op_t (3)  SRCH, RD, WR, FILL, INV.
REQ-006 req_invop / req_asid / req_va  in  5 / 10 / 32  INVTLB operands.
REQ-007 csr_index  in  TLBIDLEN  TLBIDX.index; csr_ne  in  1  TLBIDX.ne.
REQ-008 csr_entry  in  tlb_entry_t  entry assembled from TLBEHI/TLBELO0/TLBELO1/TLBIDX.ps/ASID.
REQ-009 csr_vppn / csr_asid  in  19 / 10  TLBSRCH key.
REQ-010 resp_valid / resp_ready  out / in  1 / 1  completion handshake.
REQ-011 resp_found, resp_index (TLBIDLEN), resp_entry (tlb_entry_t), resp_err  out  result to CSR writeback.
REQ-012 s_vppn 19, s_va_bit12 1, s_asid 10, s_valid 1  out  search request to the data-side TLB search port.
REQ-013 s_result  in  tlb_result_t; s_ok  in  1  search result and its validity.
REQ-014 we 1, w_index TLBIDLEN, w_entry tlb_entry_t  out  TLB write port.
REQ-015 r_index  out  TLBIDLEN; r_entry  in  tlb_entry_t  TLB read port (combinational read).
REQ-016 invtlb_valid 1, invtlb_op 5, invtlb_asid 10, invtlb_va 32  out  invalidate port.

Function
REQ-017 FSM states IDLE, SRCH, RD, WRITE, INV, SETTLE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 Accept on req_valid&req_ready in cycle T; operands latched at T; CSR inputs sampled in the state that uses them.
REQ-019 SRCH: s_valid=1, s_vppn=csr_vppn, s_va_bit12=0, s_asid=csr_asid each cycle; first cycle with s_ok captures found/index -> RESP.
REQ-020 SRCH latency: resp_valid at T+2 on first-level hit, T+3 when the TLB needs its second-level cycle.
REQ-021 SRCH: no s_ok within SRCH_TIMEOUT cycles -> RESP with resp_found=0, resp_err=1.
REQ-022 RD: r_index=csr_index for one cycle; r_entry captured into resp_entry same cycle -> RESP; resp_valid at T+2.
REQ-023 WR: we=1 exactly one cycle (T+1), w_index=csr_index; FILL: w_index=fill counter value at T+1.
REQ-024 WR/FILL with csr_ne=1: w_entry=csr_entry with e forced 0; else csr_entry unchanged.
REQ-025 INV: invop 0..6 -> invtlb_valid=1 exactly one cycle (T+1), operands from latch; invop>6 -> no invtlb_valid, RESP with resp_err=1, resp_valid at T+1.
REQ-026 After WRITE or INV: one SETTLE cycle, s_valid=0, so pending refills complete before the next op; resp_valid at T+3.
REQ-027 RESP: resp_valid and resp_* held stable until resp_ready; exit to IDLE the cycle after handshake.
REQ-028 Fill counter: TLBIDLEN bits, increments every cycle, wraps TLBNUM-1 -> 0.
REQ-029 we, invtlb_valid, s_valid SHALL never be asserted outside their states; never two in the same cycle.

Reset
REQ-030 On reset: state IDLE, fill counter 0, search-wait counter 0, resp_* 0, all valid/enable outputs 0, req_ready 1 after deassertion.
REQ-031 Reset mid-operation aborts it: no we/invtlb_valid/resp_valid produced for the aborted op.

Structure
REQ-032 tlb_op_t and the FSM state enum SHALL be added to the shared package beside tlb_entry_t, tlb_result_t, TLBNUM, TLBIDLEN.
REQ-033 Single module, no sub-module; fill and timeout counters inline.

Verification
REQ-034 SRCH, s_ok=1 at T+1, s_result.found=1 index=5 -> resp_valid T+2, found=1, index=5, err=0.
REQ-035 SRCH, s_ok=0 at T+1, 1 at T+2 with found=0 -> resp_valid T+3, found=0; s_ok never -> err=1 after 4 cycles.
REQ-036 WR csr_index=3 csr_ne=1 -> single we at T+1, w_index=3, w_entry.e=0, resp_valid T+3.
REQ-037 FILL accepted with counter at TLBNUM-1 -> w_index=TLBNUM-1, counter reads 0 next cycle.
REQ-038 INV invop=7 -> no invtlb_valid, resp_err=1 at T+1; invop=5 asid=0x12 -> one-cycle invtlb_valid at T+1, op=5, asid=0x12.
REQ-039 Reset asserted during SETTLE, resp_ready held 0 through RESP -> outputs 0 immediately, no resp_valid; resp held stable while stalled.

Source files
------------

// File: rtl/tlb_op_ctrl_pkg.sv
// Shared TLB types: entry/result layouts, table geometry, op codes and the
// op-controller FSM state encoding.
// Latency: n/a (types only).  Backpressure: n/a.
package tlb_op_ctrl_pkg;

   localparam int TLBNUM   = 16;
   localparam int TLBIDLEN = $clog2(TLBNUM);

   typedef struct packed {
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic        g;
      logic [9:0]  asid;
      logic        e;
      logic [19:0] ppn0;
      logic [1:0]  plv0;
      logic [1:0]  mat0;
      logic        d0;
      logic        v0;
      logic [19:0] ppn1;
      logic [1:0]  plv1;
      logic [1:0]  mat1;
      logic        d1;
      logic        v1;
   } tlb_entry_t;

   typedef struct packed {
      logic                found;
      logic [TLBIDLEN-1:0] index;
      logic [19:0]         ppn;
      logic [5:0]          ps;
      logic [1:0]          plv;
      logic [1:0]          mat;
      logic                d;
      logic                v;
   } tlb_result_t;

   typedef enum logic [2:0] {
      OP_SRCH = 3'd0,
      OP_RD   = 3'd1,
      OP_WR   = 3'd2,
      OP_FILL = 3'd3,
      OP_INV  = 3'd4
   } tlb_op_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SRCH   = 3'd1,
      ST_RD     = 3'd2,
      ST_WRITE  = 3'd3,
      ST_INV    = 3'd4,
      ST_SETTLE = 3'd5,
      ST_RESP   = 3'd6
   } tlb_state_t;

   // Highest INVTLB op code that is implemented.
   localparam logic [4:0] INVOP_MAX = 5'd6;

   // An entry written with TLBIDX.ne set must land as a non-existent entry.
   function automatic tlb_entry_t entry_clear_e(input tlb_entry_t ent);
      tlb_entry_t r;
      r   = ent;
      r.e = 1'b0;
      return r;
   endfunction

endpackage

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance op sequencer: runs TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB
// against the TLB ports and returns one result per accepted request.
// Latency: RD/SRCH-hit T+2, SRCH 2nd-level T+3, WR/FILL/INV T+3, bad INV T+1;
// backpressure: one op in flight, req_ready only in IDLE, result held until resp_ready.
//
// Ports:
//   clk, reset                  clock, async active-high reset
//   req_*                       op request from execute (valid/ready)
//   csr_*                       TLBIDX / TLBEHI / TLBELO* / ASID / TLBSRCH state
//   resp_*                      result to CSR writeback (valid/ready)
//   s_*                         search port (request out, s_result/s_ok in)
//   we, w_index, w_entry        write port
//   r_index, r_entry            combinational read port
//   invtlb_*                    invalidate port
module tlb_op_ctrl
   import tlb_op_ctrl_pkg::*;
#(
   parameter int SRCH_TIMEOUT = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  tlb_op_t             req_op,
   input  logic [4:0]          req_invop,
   input  logic [9:0]          req_asid,
   input  logic [31:0]         req_va,
   input  logic [TLBIDLEN-1:0] csr_index,
   input  logic                csr_ne,
   input  tlb_entry_t          csr_entry,
   input  logic [18:0]         csr_vppn,
   input  logic [9:0]          csr_asid,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic                resp_found,
   output logic [TLBIDLEN-1:0] resp_index,
   output tlb_entry_t          resp_entry,
   output logic                resp_err,
   output logic [18:0]         s_vppn,
   output logic                s_va_bit12,
   output logic [9:0]          s_asid,
   output logic                s_valid,
   input  tlb_result_t         s_result,
   input  logic                s_ok,
   output logic                we,
   output logic [TLBIDLEN-1:0] w_index,
   output tlb_entry_t          w_entry,
   output logic [TLBIDLEN-1:0] r_index,
   input  tlb_entry_t          r_entry,
   output logic                invtlb_valid,
   output logic [4:0]          invtlb_op,
   output logic [9:0]          invtlb_asid,
   output logic [31:0]         invtlb_va
);

   localparam int CW = (SRCH_TIMEOUT > 1) ? $clog2(SRCH_TIMEOUT) : 1;

   tlb_state_t          state;
   tlb_op_t             op_q;
   logic [4:0]          invop_q;
   logic [9:0]          asid_q;
   logic [31:0]         va_q;
   logic [TLBIDLEN-1:0] fill_cnt;
   logic [CW-1:0]       srch_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         op_q         <= OP_SRCH;
         invop_q      <= '0;
         asid_q       <= '0;
         va_q         <= '0;
         fill_cnt     <= '0;
         srch_cnt     <= '0;
         resp_valid   <= 1'b0;
         resp_found   <= 1'b0;
         resp_index   <= '0;
         resp_entry   <= '0;
         resp_err     <= 1'b0;
         s_valid      <= 1'b0;
         we           <= 1'b0;
         invtlb_valid <= 1'b0;
      end else begin
         // Free-running victim pointer for TLBFILL.
         fill_cnt <= (fill_cnt == TLBIDLEN'(TLBNUM - 1)) ? '0 : fill_cnt + 1'b1;

         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q       <= req_op;
                  invop_q    <= req_invop;
                  asid_q     <= req_asid;
                  va_q       <= req_va;
                  srch_cnt   <= '0;
                  resp_found <= 1'b0;
                  resp_index <= '0;
                  resp_entry <= '0;
                  resp_err   <= 1'b0;
                  case (req_op)
                     OP_SRCH: begin
                        state   <= ST_SRCH;
                        s_valid <= 1'b1;
                     end
                     OP_RD: state <= ST_RD;
                     OP_WR, OP_FILL: begin
                        state <= ST_WRITE;
                        we    <= 1'b1;
                     end
                     OP_INV: begin
                        if (req_invop <= INVOP_MAX) begin
                           state        <= ST_INV;
                           invtlb_valid <= 1'b1;
                        end else begin
                           // Unimplemented INVTLB op: report straight away.
                           state      <= ST_RESP;
                           resp_err   <= 1'b1;
                           resp_valid <= 1'b1;
                        end
                     end
                     default: begin
                        state      <= ST_RESP;
                        resp_err   <= 1'b1;
                        resp_valid <= 1'b1;
                     end
                  endcase
               end
            end
            ST_SRCH: begin
               if (s_ok) begin
                  resp_found <= s_result.found;
                  resp_index <= s_result.index;
                  s_valid    <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= ST_RESP;
               end else if (srch_cnt == CW'(SRCH_TIMEOUT - 1)) begin
                  resp_err   <= 1'b1;
                  s_valid    <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= ST_RESP;
               end else begin
                  srch_cnt <= srch_cnt + 1'b1;
               end
            end
            ST_RD: begin
               resp_entry <= r_entry;
               resp_valid <= 1'b1;
               state      <= ST_RESP;
            end
            ST_WRITE: begin
               we    <= 1'b0;
               state <= ST_SETTLE;
            end
            ST_INV: begin
               invtlb_valid <= 1'b0;
               state        <= ST_SETTLE;
            end
            // Dead cycle with the search port idle so refills triggered by the
            // table change drain before the next op can search.
            ST_SETTLE: begin
               resp_valid <= 1'b1;
               state      <= ST_RESP;
            end
            ST_RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = (state == ST_IDLE);

   // Search key is taken live from the CSRs while in SRCH.
   assign s_vppn     = csr_vppn;
   assign s_va_bit12 = 1'b0;
   assign s_asid     = csr_asid;

   assign r_index    = (state == ST_RD) ? csr_index : '0;

   assign w_index    = !we              ? '0       :
                       (op_q == OP_FILL) ? fill_cnt : csr_index;
   assign w_entry    = csr_ne ? entry_clear_e(csr_entry) : csr_entry;

   assign invtlb_op   = invop_q;
   assign invtlb_asid = asid_q;
   assign invtlb_va   = va_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Self-checking bench for tlb_op_ctrl: table of op vectors with a response
// scoreboard, plus hand sequences for FILL wrap and reset during SETTLE.
module tb_tlb_op_ctrl;
   import tlb_op_ctrl_pkg::*;

   logic                clk = 1'b0;
   logic                reset;
   logic                req_valid, req_ready;
   tlb_op_t             req_op;
   logic [4:0]          req_invop;
   logic [9:0]          req_asid;
   logic [31:0]         req_va;
   logic [TLBIDLEN-1:0] csr_index;
   logic                csr_ne;
   tlb_entry_t          csr_entry;
   logic [18:0]         csr_vppn;
   logic [9:0]          csr_asid;
   logic                resp_valid, resp_ready, resp_found, resp_err;
   logic [TLBIDLEN-1:0] resp_index;
   tlb_entry_t          resp_entry;
   logic [18:0]         s_vppn;
   logic                s_va_bit12, s_valid, s_ok;
   logic [9:0]          s_asid;
   tlb_result_t         s_result;
   logic                we;
   logic [TLBIDLEN-1:0] w_index, r_index;
   tlb_entry_t          w_entry, r_entry;
   logic                invtlb_valid;
   logic [4:0]          invtlb_op;
   logic [9:0]          invtlb_asid;
   logic [31:0]         invtlb_va;

   always #5 clk = ~clk;

   tlb_op_ctrl #(.SRCH_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_invop(req_invop), .req_asid(req_asid), .req_va(req_va),
      .csr_index(csr_index), .csr_ne(csr_ne), .csr_entry(csr_entry),
      .csr_vppn(csr_vppn), .csr_asid(csr_asid),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_found(resp_found),
      .resp_index(resp_index), .resp_entry(resp_entry), .resp_err(resp_err),
      .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid), .s_valid(s_valid),
      .s_result(s_result), .s_ok(s_ok),
      .we(we), .w_index(w_index), .w_entry(w_entry),
      .r_index(r_index), .r_entry(r_entry),
      .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op),
      .invtlb_asid(invtlb_asid), .invtlb_va(invtlb_va)
   );

   // Tiny TLB model: each index reads back a distinct entry.
   function automatic tlb_entry_t mk_entry(input logic [TLBIDLEN-1:0] idx);
      tlb_entry_t e;
      e      = '0;
      e.vppn = {15'h1a5, idx};
      e.ps   = 6'd12;
      e.asid = {6'h3c, idx};
      e.e    = 1'b1;
      e.ppn0 = {16'hbeef, idx};
      e.v0   = 1'b1;
      e.ppn1 = {16'hcafe, idx};
      return e;
   endfunction
   assign r_entry = mk_entry(r_index);

   // Reference fill pointer: cycles since reset release, modulo TLBNUM.
   int fc;
   always @(posedge clk or posedge reset) begin
      if (reset) fc <= 0;
      else       fc <= (fc + 1) % TLBNUM;
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      tlb_op_t             op;
      logic [4:0]          invop;
      logic [9:0]          asid;
      logic [31:0]         va;
      logic [TLBIDLEN-1:0] idx;
      logic                ne;
      int                  ok_at;   // cycle after accept where s_ok rises, 0 = never
      logic                s_found;
      logic [TLBIDLEN-1:0] s_idx;
      int                  stall;   // cycles resp_ready held low after resp_valid
      int                  widx;    // expected w_index, -1 = reference fill pointer
      int                  lat;     // resp_valid cycle after accept
      logic                e_found;
      logic [TLBIDLEN-1:0] e_idx;
      logic                e_err;
      logic                e_we;
      logic                e_inv;
   } vec_t;

   typedef struct {
      logic                found;
      logic [TLBIDLEN-1:0] index;
      tlb_entry_t          entry;
      logic                err;
   } exp_t;

   exp_t sbq[$];

   task automatic run_vec(input vec_t v, input string tag);
      exp_t       e;
      tlb_entry_t ew;
      bit         seen;
      @(negedge clk);
      chk({tag, ".req_ready"}, 128'(req_ready), 128'(1'b1));
      req_valid  = 1'b1;
      req_op     = v.op;
      req_invop  = v.invop;
      req_asid   = v.asid;
      req_va     = v.va;
      csr_index  = v.idx;
      csr_ne     = v.ne;
      resp_ready = (v.stall == 0);
      e.found = v.e_found;
      e.index = v.e_idx;
      e.err   = v.e_err;
      e.entry = (v.op == OP_RD) ? mk_entry(v.idx) : '0;
      sbq.push_back(e);
      ew = csr_entry;
      if (v.ne) ew.e = 1'b0;
      seen = 1'b0;
      @(posedge clk);
      for (int k = 1; k <= 16 && !seen; k++) begin
         #1;
         req_valid       = 1'b0;
         s_ok            = (v.ok_at != 0) && (k == v.ok_at);
         s_result        = '0;
         s_result.found  = v.s_found;
         s_result.index  = v.s_idx;
         @(negedge clk);
         chk({tag, ".we"}, 128'(we), 128'(v.e_we && k == 1));
         chk({tag, ".invtlb_valid"}, 128'(invtlb_valid), 128'(v.e_inv && k == 1));
         chk({tag, ".s_valid"}, 128'(s_valid), 128'(v.op == OP_SRCH && k < v.lat));
         if (v.op == OP_RD && k == 1)
            chk({tag, ".r_index"}, 128'(r_index), 128'(v.idx));
         if (we) begin
            chk({tag, ".w_index"}, 128'(w_index),
                (v.widx < 0) ? 128'(fc) : 128'(v.widx));
            chk({tag, ".w_entry"}, 128'(w_entry), 128'(ew));
         end
         if (invtlb_valid) begin
            chk({tag, ".invtlb_op"}, 128'(invtlb_op), 128'(v.invop));
            chk({tag, ".invtlb_asid"}, 128'(invtlb_asid), 128'(v.asid));
            chk({tag, ".invtlb_va"}, 128'(invtlb_va), 128'(v.va));
         end
         if (s_valid) begin
            chk({tag, ".s_vppn"}, 128'(s_vppn), 128'(19'h5a5a5));
            chk({tag, ".s_asid"}, 128'(s_asid), 128'(10'h2b3));
            chk({tag, ".s_va_bit12"}, 128'(s_va_bit12), 128'(1'b0));
         end
         if (resp_valid) begin
            seen = 1'b1;
            chk({tag, ".latency"}, 128'(k), 128'(v.lat));
            if (sbq.size() == 0) begin
               checks++; failures++;
               $display("FAIL %s.scoreboard: got response, expected none", tag);
            end else begin
               e = sbq.pop_front();
               chk({tag, ".resp_found"}, 128'(resp_found), 128'(e.found));
               chk({tag, ".resp_index"}, 128'(resp_index), 128'(e.index));
               chk({tag, ".resp_err"}, 128'(resp_err), 128'(e.err));
               chk({tag, ".resp_entry"}, 128'(resp_entry), 128'(e.entry));
               for (int s = 0; s < v.stall; s++) begin
                  @(posedge clk);
                  #1;
                  if (s == v.stall - 1) resp_ready = 1'b1;
                  @(negedge clk);
                  chk({tag, ".stall_valid"}, 128'(resp_valid), 128'(1'b1));
                  chk({tag, ".stall_ready"}, 128'(req_ready), 128'(1'b0));
                  chk({tag, ".stall_found"}, 128'(resp_found), 128'(e.found));
                  chk({tag, ".stall_index"}, 128'(resp_index), 128'(e.index));
                  chk({tag, ".stall_err"}, 128'(resp_err), 128'(e.err));
               end
            end
         end
         @(posedge clk);
      end
      if (!seen) begin
         checks++; failures++;
         $display("FAIL %s.timeout: got no resp_valid, expected one within 16 cycles", tag);
         sbq.delete();
      end
      s_ok       = 1'b0;
      resp_ready = 1'b1;
   endtask

   vec_t vt[12];
   vec_t fv;

   initial begin
      //          op       invop  asid    va            idx   ne    ok  sfnd  sidx  stl widx lat efnd eidx  eerr  ewe   einv
      vt[0]  = '{OP_SRCH, 5'd0, 10'h0,  32'h0,        4'd0, 1'b0, 1, 1'b1, 4'd5,  0, -1, 2, 1'b1, 4'd5,  1'b0, 1'b0, 1'b0};
      vt[1]  = '{OP_SRCH, 5'd0, 10'h0,  32'h0,        4'd0, 1'b0, 2, 1'b0, 4'd0,  0, -1, 3, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
      vt[2]  = '{OP_SRCH, 5'd0, 10'h0,  32'h0,        4'd0, 1'b0, 0, 1'b1, 4'd9,  0, -1, 5, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0};
      vt[3]  = '{OP_RD,   5'd0, 10'h0,  32'h0,        4'd7, 1'b0, 0, 1'b0, 4'd0,  0, -1, 2, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
      vt[4]  = '{OP_WR,   5'd0, 10'h0,  32'h0,        4'd3, 1'b1, 0, 1'b0, 4'd0,  0,  3, 3, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0};
      vt[5]  = '{OP_WR,   5'd0, 10'h0,  32'h0,        4'd9, 1'b0, 0, 1'b0, 4'd0,  0,  9, 3, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0};
      vt[6]  = '{OP_FILL, 5'd0, 10'h0,  32'h0,        4'd2, 1'b0, 0, 1'b0, 4'd0,  0, -1, 3, 1'b0, 4'd0,  1'b0, 1'b1, 1'b0};
      vt[7]  = '{OP_INV,  5'd7, 10'h0,  32'h0,        4'd0, 1'b0, 0, 1'b0, 4'd0,  0, -1, 1, 1'b0, 4'd0,  1'b1, 1'b0, 1'b0};
      vt[8]  = '{OP_INV,  5'd5, 10'h12, 32'h8000_1000, 4'd0, 1'b0, 0, 1'b0, 4'd0,  0, -1, 3, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1};
      vt[9]  = '{OP_INV,  5'd6, 10'h3ff, 32'h1234_5000, 4'd0, 1'b0, 0, 1'b0, 4'd0,  0, -1, 3, 1'b0, 4'd0,  1'b0, 1'b0, 1'b1};
      vt[10] = '{OP_SRCH, 5'd0, 10'h0,  32'h0,        4'd0, 1'b0, 3, 1'b1, 4'd15, 0, -1, 4, 1'b1, 4'd15, 1'b0, 1'b0, 1'b0};
      vt[11] = '{OP_SRCH, 5'd0, 10'h0,  32'h0,        4'd0, 1'b0, 1, 1'b1, 4'd11, 3, -1, 2, 1'b1, 4'd11, 1'b0, 1'b0, 1'b0};

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_op     = OP_SRCH;
      req_invop  = '0;
      req_asid   = '0;
      req_va     = '0;
      csr_index  = '0;
      csr_ne     = 1'b0;
      csr_entry  = mk_entry(4'hA);
      csr_vppn   = 19'h5a5a5;
      csr_asid   = 10'h2b3;
      resp_ready = 1'b1;
      s_ok       = 1'b0;
      s_result   = '0;

      repeat (2) @(negedge clk);
      chk("reset.resp_valid", 128'(resp_valid), 128'(1'b0));
      chk("reset.we", 128'(we), 128'(1'b0));
      chk("reset.s_valid", 128'(s_valid), 128'(1'b0));
      chk("reset.invtlb_valid", 128'(invtlb_valid), 128'(1'b0));
      chk("reset.resp_fields", 128'({resp_found, resp_err, resp_index}), 128'(0));
      chk("reset.resp_entry", 128'(resp_entry), 128'(0));
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset.req_ready", 128'(req_ready), 128'(1'b1));

      foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));

      // FILL issued so that the pointer reads TLBNUM-1 in the write cycle,
      // then a second FILL to confirm the pointer wrapped and kept counting.
      for (int n = 0; n < 40 && fc != TLBNUM - 3; n++) @(negedge clk);
      fv = vt[6];
      fv.widx = TLBNUM - 1;
      run_vec(fv, "fill_wrap");
      fv.widx = -1;
      run_vec(fv, "fill_after_wrap");

      // Reset during SETTLE of a WR with resp_ready low: everything drops at
      // once and the aborted op never produces a response.
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = OP_WR;
      csr_index = 4'd4;
      csr_ne    = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("rst_mid.we_t1", 128'(we), 128'(1'b1));
      @(negedge clk);
      resp_ready = 1'b0;
      reset      = 1'b1;
      #1;
      chk("rst_mid.outputs", 128'({we, invtlb_valid, s_valid, resp_valid}), 128'(0));
      chk("rst_mid.resp_fields", 128'({resp_found, resp_err, resp_index}), 128'(0));
      @(negedge clk);
      reset = 1'b0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         chk("rst_mid.no_resp", 128'(resp_valid), 128'(1'b0));
         chk("rst_mid.idle", 128'(req_ready), 128'(1'b1));
         chk("rst_mid.no_we", 128'(we), 128'(1'b0));
      end
      resp_ready = 1'b1;

      // Controller still usable after the abort.
      run_vec(vt[0], "post_abort");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish before 200us");
      $fatal(1);
   end

endmodule
